// File: rtl/net_sched_if.sv
// Host and neuron-side signals of the letter-network scheduler.
// Pure wiring: no latency of its own.
// Backpressure: none; start/done and nrn_start/nrn_valid are single-cycle pulses.
interface net_sched_if;
    logic         start;
    logic [7:0]   x3;
    logic [7:0]   x2;
    logic [7:0]   x1;
    logic [7:0]   x0;

    logic [4:0]   rom_addr;
    logic         nrn_start;
    logic [7:0]   nrn_x3;
    logic [7:0]   nrn_x2;
    logic [7:0]   nrn_x1;
    logic [7:0]   nrn_x0;
    logic [7:0]   nrn_y;
    logic         nrn_valid;

    logic [207:0] scores;
    logic [4:0]   letter;
    logic         busy;
    logic         done;

    modport master (
        input  start, x3, x2, x1, x0, nrn_y, nrn_valid,
        output rom_addr, nrn_start, nrn_x3, nrn_x2, nrn_x1, nrn_x0,
               scores, letter, busy, done
    );

    modport slave (
        output start, x3, x2, x1, x0, nrn_y, nrn_valid,
        input  rom_addr, nrn_start, nrn_x3, nrn_x2, nrn_x1, nrn_x0,
               scores, letter, busy, done
    );
endinterface

// File: rtl/net_sched.sv
// Runs the 4-hidden / 26-output letter network row by row on one shared neuron.
// Latency: done 30*L+31 cycles after start, L = neuron latency.
// Backpressure: start ignored while busy; nrn_valid only accepted while waiting.
module net_sched (
    input  logic        clk,
    input  logic        rst,
    net_sched_if.master bus
);
    localparam logic [4:0] LAST_ROW = 5'd29;
    localparam logic [4:0] FIRST_L1 = 5'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] v3;
        logic [7:0] v2;
        logic [7:0] v1;
        logic [7:0] v0;
    } opnd_t;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       idx;
    opnd_t            x_q;
    opnd_t            h_q;
    opnd_t            opnd;
    logic [25:0][7:0] scores_q;
    logic [7:0]       best_val;
    logic [4:0]       best_idx;
    logic [4:0]       letter_q;

    logic             accept;
    logic             res_vld;
    logic             in_l1;
    logic [4:0]       slot;
    logic [7:0]       best_val_nxt;
    logic [4:0]       best_idx_nxt;
    logic             nrn_start_c;
    logic             busy_c;
    logic             done_c;

    assign accept  = (state == S_IDLE) && bus.start;
    assign res_vld = (state == S_WAIT) && bus.nrn_valid;
    assign in_l1   = (idx >= FIRST_L1);
    assign slot    = idx - FIRST_L1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        nrn_start_c = 1'b0;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                nrn_start_c = 1'b1;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.nrn_valid) begin
                    state_nxt = (idx == LAST_ROW) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Row index doubles as the ROM address; it is left at 29 after a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 5'd0;
            x_q <= '0;
        end else if (accept) begin
            idx <= 5'd0;
            x_q <= '{v3: bus.x3, v2: bus.x2, v1: bus.x1, v0: bus.x0};
        end else if (res_vld && (idx != LAST_ROW)) begin
            idx <= idx + 5'd1;
        end
    end

    // Layer-0 rows fill the hidden registers from the top: row 0 is h3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
        end else if (res_vld && !in_l1) begin
            case (idx[1:0])
                2'd0:    h_q.v3 <= bus.nrn_y;
                2'd1:    h_q.v2 <= bus.nrn_y;
                2'd2:    h_q.v1 <= bus.nrn_y;
                default: h_q.v0 <= bus.nrn_y;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scores_q <= '0;
        end else if (res_vld && in_l1) begin
            scores_q[slot] <= bus.nrn_y;
        end
    end

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        best_val_nxt = best_val;
        best_idx_nxt = best_idx;
        if ((slot == 5'd0) || (bus.nrn_y > best_val)) begin
            best_val_nxt = bus.nrn_y;
            best_idx_nxt = slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val <= 8'd0;
            best_idx <= 5'd0;
            letter_q <= 5'd0;
        end else if (res_vld && in_l1) begin
            best_val <= best_val_nxt;
            best_idx <= best_idx_nxt;
            if (idx == LAST_ROW) begin
                letter_q <= best_idx_nxt;
            end
        end
    end

    // Operands decode from registered state only, so they stay put through WAIT.
    assign opnd = in_l1 ? h_q : x_q;

    assign bus.rom_addr  = idx;
    assign bus.nrn_start = nrn_start_c;
    assign bus.nrn_x3    = opnd.v3;
    assign bus.nrn_x2    = opnd.v2;
    assign bus.nrn_x1    = opnd.v1;
    assign bus.nrn_x0    = opnd.v0;
    assign bus.scores    = scores_q;
    assign bus.letter    = letter_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
endmodule

// File: tb/tb_net_sched.sv
`timescale 1ns/1ps
module tb_net_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    net_sched_if bus();

    net_sched u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]   resp [0:29];
    int           lat  = 1;
    bit           spur = 1'b0;

    logic [4:0]   issue_addr [$];
    logic [31:0]  issue_ops  [$];
    int           stab_err = 0;
    int           cnt      = 0;
    logic [4:0]   cur_addr;
    logic [31:0]  cur_ops;

    logic [207:0] prev_sc;
    logic [4:0]   prev_let;
    bit           have_prev = 1'b0;

    // Neuron stub: answers resp[row] L cycles after each strobe, driven on negedges.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt           = 0;
            bus.nrn_valid = 1'b0;
            bus.nrn_y     = 8'd0;
        end else begin
            bus.nrn_valid = 1'b0;
            if (cnt > 0) begin
                if (bus.rom_addr !== cur_addr || bus.nrn_start !== 1'b0 ||
                    {bus.nrn_x3, bus.nrn_x2, bus.nrn_x1, bus.nrn_x0} !== cur_ops)
                    stab_err++;
                cnt--;
                if (cnt == 0) begin
                    bus.nrn_valid = 1'b1;
                    bus.nrn_y     = resp[cur_addr];
                end
            end
            if (bus.nrn_start === 1'b1) begin
                cur_addr = bus.rom_addr;
                cur_ops  = {bus.nrn_x3, bus.nrn_x2, bus.nrn_x1, bus.nrn_x0};
                issue_addr.push_back(cur_addr);
                issue_ops.push_back(cur_ops);
                cnt = lat;
                if (spur) begin
                    bus.nrn_valid = 1'b1;
                    bus.nrn_y     = 8'hEE;
                end
            end
        end
    end

    task automatic do_run(input string tag, input logic [7:0] a3, input logic [7:0] a2,
                          input logic [7:0] a1, input logic [7:0] a0,
                          input int l, input bit sp, input bit dbl);
        logic [207:0] exp_sc;
        logic [4:0]   exp_let;
        logic [31:0]  exp_op;
        int best, n, done_cyc, busy_err, seq_err, q0, s0, exp_done;
        best = 0;
        for (int k = 1; k < 26; k++)
            if (resp[k+4] > resp[best+4]) best = k;
        exp_let = best[4:0];
        for (int k = 0; k < 26; k++) exp_sc[k*8 +: 8] = resp[k+4];
        exp_done = 30 * l + 31;
        lat  = l;
        spur = sp;
        q0 = issue_addr.size();
        s0 = stab_err;

        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_before_start: busy=%b done=%b required 0/0", tag, bus.busy, bus.done);
        end
        bus.start = 1'b1;
        bus.x3 = a3; bus.x2 = a2; bus.x1 = a1; bus.x0 = a0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x3 = 8'($urandom); bus.x2 = 8'($urandom); bus.x1 = 8'($urandom); bus.x0 = 8'($urandom);
        n = 1; done_cyc = -1; busy_err = 0;
        while (done_cyc < 0 && n <= 400) begin
            if (bus.busy !== 1'b1) busy_err++;
            if (n == 2 && have_prev) begin
                checks++;
                if (bus.scores !== prev_sc || bus.letter !== prev_let) begin
                    failures++;
                    $display("FAIL %s held_from_prev: letter=%0d required %0d scores=%h required %h",
                             tag, bus.letter, prev_let, bus.scores, prev_sc);
                end
            end
            if (bus.done === 1'b1) begin
                done_cyc = n;
            end else begin
                bus.start = (dbl && n == 10);
                if (dbl && n == 10) begin
                    bus.x3 = 8'hFF; bus.x2 = 8'hFF; bus.x1 = 8'hFF; bus.x0 = 8'hFF;
                end
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b0;

        checks++;
        if (done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d required %0d (-1 = timeout)", tag, done_cyc, exp_done);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s busy_profile: %0d low cycles while running, required 0", tag, busy_err);
        end
        checks++;
        if (issue_addr.size() - q0 != 30) begin
            failures++;
            $display("FAIL %s issue_count: got %0d required 30", tag, issue_addr.size() - q0);
        end
        seq_err = 0;
        for (int i = 0; i < 30; i++) begin
            exp_op = (i < 4) ? {a3, a2, a1, a0} : {resp[0], resp[1], resp[2], resp[3]};
            if (q0 + i < issue_addr.size()) begin
                if (issue_addr[q0+i] !== 5'(i) || issue_ops[q0+i] !== exp_op) begin
                    if (seq_err == 0)
                        $display("FAIL %s issue_row%0d: addr=%0d ops=%h required addr=%0d ops=%h",
                                 tag, i, issue_addr[q0+i], issue_ops[q0+i], i, exp_op);
                    seq_err++;
                end
            end
        end
        checks++;
        if (seq_err != 0) begin
            failures++;
            $display("FAIL %s issue_sequence: %0d bad rows, required 0", tag, seq_err);
        end
        checks++;
        if (stab_err - s0 != 0) begin
            failures++;
            $display("FAIL %s wait_stability: %0d unstable cycles, required 0", tag, stab_err - s0);
        end
        checks++;
        if (bus.scores !== exp_sc) begin
            failures++;
            $display("FAIL %s scores: got %h required %h", tag, bus.scores, exp_sc);
        end
        checks++;
        if (bus.letter !== exp_let) begin
            failures++;
            $display("FAIL %s letter: got %0d required %0d", tag, bus.letter, exp_let);
        end
        prev_sc   = exp_sc;
        prev_let  = exp_let;
        have_prev = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.x3 = 8'd0; bus.x2 = 8'd0; bus.x1 = 8'd0; bus.x0 = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rom_addr !== 5'd0 || bus.nrn_start !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: rom_addr=%0d nrn_start=%b busy=%b done=%b required 0",
                     bus.rom_addr, bus.nrn_start, bus.busy, bus.done);
        end
        checks++;
        if ({bus.nrn_x3, bus.nrn_x2, bus.nrn_x1, bus.nrn_x0} !== 32'd0 ||
            bus.scores !== 208'd0 || bus.letter !== 5'd0) begin
            failures++;
            $display("FAIL reset_data: ops=%h letter=%0d scores=%h required all 0",
                     {bus.nrn_x3, bus.nrn_x2, bus.nrn_x1, bus.nrn_x0}, bus.letter, bus.scores);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.nrn_start !== 1'b0 || bus.rom_addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b nrn_start=%b rom_addr=%0d required 0",
                     bus.busy, bus.nrn_start, bus.rom_addr);
        end
        prev_sc = '0; prev_let = '0; have_prev = 1'b1;
    endtask

    task automatic test_ramp;
        for (int i = 0; i < 30; i++) resp[i] = 8'(i + 1);
        do_run("ramp", 8'h10, 8'h20, 8'h30, 8'h40, 1, 1'b0, 1'b0);
    endtask

    task automatic test_peak;
        for (int i = 0; i < 30; i++) resp[i] = 8'd50;
        resp[9] = 8'd200;
        do_run("peak", 8'h01, 8'h02, 8'h03, 8'h04, 1, 1'b0, 1'b0);
        resp[20] = 8'd200;
        do_run("peak_tie", 8'h05, 8'h06, 8'h07, 8'h08, 1, 1'b0, 1'b0);
    endtask

    task automatic test_latency5;
        for (int i = 0; i < 30; i++) resp[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) resp[i] = 8'(i + 1);
        do_run("lat5", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 5, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        for (int i = 0; i < 30; i++) resp[i] = 8'(i + 1);
        do_run("ignored", 8'h10, 8'h20, 8'h30, 8'h40, 1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        int n, dn, bz;
        for (int i = 0; i < 30; i++) resp[i] = 8'($urandom_range(1, 255));
        lat = 1; spur = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x3 = 8'($urandom); bus.x2 = 8'($urandom); bus.x1 = 8'($urandom); bus.x0 = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (n < 26) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.rom_addr !== 5'd12 || bus.nrn_start !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_point: rom_addr=%0d nrn_start=%b busy=%b required 12/0/1",
                     bus.rom_addr, bus.nrn_start, bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rom_addr !== 5'd0 || bus.nrn_start !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_ctrl_zero: rom_addr=%0d nrn_start=%b busy=%b done=%b required 0",
                     bus.rom_addr, bus.nrn_start, bus.busy, bus.done);
        end
        checks++;
        if ({bus.nrn_x3, bus.nrn_x2, bus.nrn_x1, bus.nrn_x0} !== 32'd0 ||
            bus.scores !== 208'd0 || bus.letter !== 5'd0) begin
            failures++;
            $display("FAIL abort_data_zero: ops=%h letter=%0d scores=%h required all 0",
                     {bus.nrn_x3, bus.nrn_x2, bus.nrn_x1, bus.nrn_x0}, bus.letter, bus.scores);
        end
        @(negedge clk);
        rst = 1'b0;
        dn = 0; bz = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
            if (bus.busy !== 1'b0) bz++;
        end
        checks++;
        if (dn != 0 || bz != 0) begin
            failures++;
            $display("FAIL abort_no_done: done pulses=%0d busy cycles=%0d required 0/0", dn, bz);
        end
        prev_sc = '0; prev_let = '0; have_prev = 1'b1;
        for (int i = 0; i < 30; i++) resp[i] = 8'($urandom);
        do_run("post_abort", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 30; i++) resp[i] = 8'($urandom);
        do_run("b2b_first", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) resp[i] = 8'($urandom);
        do_run("b2b_second", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 30; i++) resp[i] = 8'($urandom_range(0, 15));
            do_run($sformatf("rand%0d", r), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.x3 = 8'd0; bus.x2 = 8'd0; bus.x1 = 8'd0; bus.x0 = 8'd0;
        for (int i = 0; i < 30; i++) resp[i] = 8'd0;
        test_reset();
        test_ramp();
        test_peak();
        test_latency5();
        test_ignored_inputs();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/net_sched.md
# net_sched

Time-multiplexed scheduler that evaluates the full two-layer letter network (4 hidden neurons, 26 output neurons) on one shared `neuron` instance instead of 30 parallel ones. It sits between the deserializer and the 7-segment display ROM inside the Morse decoder. It steps through the 30 weight-ROM rows in order and drives the shared neuron's operands and start strobe. It collects the hidden and output results and reports the 26 letter scores plus the index of the highest score.

## Interface
- No parameters. Row count is fixed at 30: rows 0–3 are layer 0, rows 4–29 are layer 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; samples `x3..x0`. Same role as the deserializer's ready.
- x3, x2, x1, x0  in  8 each  network inputs, valid in the `start` cycle.
- rom_addr  out  5  weight-ROM row index (0–29). ROM read is combinational; weights go straight to the neuron.
- nrn_start  out  1  one-cycle start strobe to the shared neuron (its `new` input).
- nrn_x3, nrn_x2, nrn_x1, nrn_x0  out  8 each  neuron operands.
- nrn_y  in  8  neuron result, unsigned.
- nrn_valid  in  1  one-cycle pulse; `nrn_y` is valid in that cycle.
- scores  out  208  letter scores; letter a is [7:0], z is [207:200].
- letter  out  5  argmax index (a=0 … z=25).
- busy  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- done  out  1  one-cycle pulse; `letter` and `scores` are final.

## Operation
- **States:**
  - IDLE: `start`=1 → capture `x3..x0` into input registers, idx←0, go to ISSUE.
  - ISSUE: `nrn_start`=1 for exactly this cycle; unconditionally go to WAIT.
  - WAIT: on `nrn_valid`, store the result.
    - idx=29 → DONE.
    - otherwise idx←idx+1, go to ISSUE.
  - DONE: `done`=1, `letter` updated; go to IDLE.
- **ROM address:** `rom_addr` = idx in every state. Holds its last value in IDLE.
- **Operand mux:**
  - idx 0–3: `nrn_x3..0` = captured x3..x0.
  - idx 4–29: `nrn_x3..0` = hidden registers h3..h0.
  - Operands and `rom_addr` are stable from ISSUE until `nrn_valid` arrives.
- **Result routing:**
  - Layer 0: idx 0→h3, idx 1→h2, idx 2→h1, idx 3→h0.
  - Layer 1: idx k (4–29) → `scores` slot k−4.
- **Argmax:**
  - Tracked incrementally during layer 1, unsigned 8-bit compare.
  - Slot 0 initialises best to its score, with index 0.
  - A later slot replaces best only if strictly greater, so ties resolve to the lowest index.
  - `letter` is loaded from the tracked index on entry to DONE and is otherwise held.
- **Scores:** each slot is written as its result arrives. All slots hold until overwritten by the next run; they are not cleared at `start`.
- **Ignored inputs:**
  - `start` while not in IDLE (including DONE) is ignored.
  - `nrn_valid` outside WAIT, including a pulse coincident with ISSUE, is ignored.
- **Reset (asynchronous, any state):**
  - State goes to IDLE; idx and `rom_addr` go to 0.
  - `nrn_start`, `busy`, `done` go to 0.
  - Operand outputs, the x/h registers, `scores`, `letter` and the best-score tracker all go to 0.
  - A run interrupted by reset is lost. No `done` is produced for it.

## Timing
- The edge at which `start` is sampled is edge 0.
  - ISSUE for row k occupies cycle 1+k(L+1), where L ≥ 1 is the neuron latency from `nrn_start` to `nrn_valid`.
  - The row-29 `nrn_valid` arrives in cycle 30L+30.
  - DONE (`done`=1) is in cycle 30L+31.
  - With L=1, `done` is in cycle 61.
- A new `start` is accepted in the cycle after DONE at the earliest. The interval between `start` pulses is therefore at least 30L+32 cycles.
- `busy` rises in cycle 1 and falls in cycle 30L+32.
- All outputs are registered or decoded from registered state only. There is no combinational path from `nrn_y` or `nrn_valid` to any output.

## Test plan
1. Reset, then `start` with x=8'h10,8'h20,8'h30,8'h40. Stub neuron with L=1, returning rom_addr+1. Required response:
   - `nrn_start` pulses 30 times with `rom_addr` 0..29.
   - `done` in cycle 61.
   - Slot k holds k+5.
   - `letter`=25.
2. Stub returns 8'd50 for every row except rom_addr 9, which returns 8'd200 → `letter`=5 (f).
   - Rerun with rows 9 and 20 both at 8'd200 → `letter`=5 (tie goes to the lowest index).
3. Stub with L=5 and results of 1..4 for rows 0–3. Required response:
   - `nrn_x3..0` equals 1,2,3,4 from row 4 on.
   - Operands are stable through each WAIT.
   - `done` in cycle 181.
4. Second `start` at cycle 10 of a run, plus a spurious `nrn_valid` during ISSUE → both ignored, and results are identical to scenario 1.
5. Assert `rst` in WAIT of row 12 → all outputs read 0 immediately, with no `done`. A fresh `start` then completes normally.
6. Back-to-back runs with `start` in the cycle after DONE → the second run is accepted. Its `scores` overwrite the first run's, and a second `done` pulse follows.
